bram_port_arbiter: RTL and testbench

- Parametrised, registered successor to the cstate-driven BRAM port mux.
- Routes one simple-dual-port BRAM (one write port, one read port) to one of NCH requesting phase engines (AtG, PAcc, INTT, ...), selected by the top-level cstate through a compile-time owner map.
- Adds features the combinational mux lacks:
  - registered BRAM drive;
  - read-return tagging, so only the issuing channel sees rvalid;
  - safe ownership hand-over that drains in-flight reads first;
  - sticky error capture for accesses from non-owners.

---
 rtl/kyber_ctrl_pkg.sv | 36 +++
 rtl/bram_rd_tag_pipe.sv | 37 +++
 rtl/bram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_ctrl_pkg.sv
// Shared control constants for the Kyber datapath: cstate encodings, BRAM
// channel indices and the default cstate-to-channel owner map.
package kyber_ctrl_pkg;

  localparam int unsigned KC_ST_W  = 4;
  localparam int unsigned KC_CH_W  = 3;
  localparam int unsigned KC_NCH   = 4;
  localparam int unsigned KC_MAP_W = (2**KC_ST_W) * KC_CH_W;

  localparam logic [KC_ST_W-1:0] ST_IDLE   = 4'd0;
  localparam logic [KC_ST_W-1:0] ST_UNPACK = 4'd1;
  localparam logic [KC_ST_W-1:0] ST_HASH   = 4'd2;
  localparam logic [KC_ST_W-1:0] ST_NTT    = 4'd3;
  localparam logic [KC_ST_W-1:0] ST_PACC   = 4'd4;
  localparam logic [KC_ST_W-1:0] ST_INTT   = 4'd5;
  localparam logic [KC_ST_W-1:0] ST_ADD    = 4'd6;
  localparam logic [KC_ST_W-1:0] ST_REDUCE = 4'd7;
  localparam logic [KC_ST_W-1:0] ST_PACK   = 4'd8;

  localparam logic [KC_CH_W-1:0] CH_ATG  = 3'd0;
  localparam logic [KC_CH_W-1:0] CH_PACC = 3'd1;
  localparam logic [KC_CH_W-1:0] CH_INTT = 3'd2;
  localparam logic [KC_CH_W-1:0] CH_NONE = KC_CH_W'(KC_NCH);

  // Flattened owner map: Hash->AtG, PAcc->PAcc, INTT->INTT, everything else unowned.
  function automatic logic [KC_MAP_W-1:0] build_owner_map();
    logic [KC_MAP_W-1:0] m;
    m = '0;
    for (int s = 0; s < (2**KC_ST_W); s++) m[s*KC_CH_W +: KC_CH_W] = CH_NONE;
    m[int'(ST_HASH)*KC_CH_W +: KC_CH_W] = CH_ATG;
    m[int'(ST_PACC)*KC_CH_W +: KC_CH_W] = CH_PACC;
    m[int'(ST_INTT)*KC_CH_W +: KC_CH_W] = CH_INTT;
    return m;
  endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// RLAT-deep shift pipeline carrying {valid, channel id} alongside BRAM reads,
// so the read return can be steered back to the issuing channel.
module bram_rd_tag_pipe #(
  parameter int unsigned RLAT = 1,
  parameter int unsigned CH_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [CH_W-1:0] push_id,
  output logic            tail_valid,
  output logic [CH_W-1:0] tail_id,
  output logic            empty_c
);

  logic [RLAT-1:0]           valid_q;
  logic [RLAT-1:0][CH_W-1:0] id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q[0] <= push;
      id_q[0]    <= push ? push_id : '0;
      for (int i = 1; i < RLAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign tail_valid = valid_q[RLAT-1];
  assign tail_id    = id_q[RLAT-1];
  assign empty_c    = ~|valid_q;

endmodule

// File: rtl/bram_port_arbiter.sv
// Registered BRAM port arbiter: forwards the cstate-selected owner's requests,
// tags read returns, drains in-flight reads on hand-over, flags non-owner access.
module bram_port_arbiter
  import kyber_ctrl_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CH_W = 3,
  parameter int unsigned ST_W = 4,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 128,
  parameter int unsigned RLAT = 1,
  parameter logic [(2**ST_W)*CH_W-1:0] OWNER_MAP = {(2**ST_W){CH_W'(NCH)}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ST_W-1:0]   cstate,
  input  logic [NCH-1:0]    ch_wen,
  input  logic [NCH*AW-1:0] ch_waddr,
  input  logic [NCH*DW-1:0] ch_wdata,
  input  logic [NCH-1:0]    ch_ren,
  input  logic [NCH*AW-1:0] ch_raddr,
  output logic [DW-1:0]     ch_rdata,
  output logic [NCH-1:0]    ch_rvalid,
  output logic              bram_wen,
  output logic [AW-1:0]     bram_waddr,
  output logic [DW-1:0]     bram_wdata,
  output logic              bram_ren,
  output logic [AW-1:0]     bram_raddr,
  input  logic [DW-1:0]     bram_rdata,
  output logic [CH_W-1:0]   owner,
  output logic              busy,
  output logic              err,
  output logic [CH_W-1:0]   err_ch,
  input  logic              err_clr
);

  localparam logic [CH_W-1:0] NONE    = CH_W'(NCH);
  localparam logic [0:0]      S_OWN   = 1'b0;
  localparam logic [0:0]      S_DRAIN = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CH_W-1:0] owner_q, owner_d;
  logic            busy_q, busy_d;
  logic [CH_W-1:0] tgt_raw_c, tgt_c;
  logic            fwd_c;
  logic [NCH-1:0]  owner_oh_c, viol_c, rvalid_c;
  logic            wen_c, ren_c;
  logic [AW-1:0]   waddr_c, raddr_c;
  logic [DW-1:0]   wdata_c;
  logic [CH_W-1:0] viol_lo_c;
  logic            pipe_empty_c, tail_valid;
  logic [CH_W-1:0] tail_id;

  assign tgt_raw_c = OWNER_MAP[cstate*CH_W +: CH_W];
  assign tgt_c     = (tgt_raw_c >= NONE) ? NONE : tgt_raw_c;

  // Owner request mux; forwarding stops the same cycle the target moves away.
  always_comb begin
    owner_oh_c = '0;
    wen_c      = 1'b0;
    ren_c      = 1'b0;
    waddr_c    = '0;
    raddr_c    = '0;
    wdata_c    = '0;
    fwd_c      = (state_q == S_OWN) && (owner_q < NONE) && (tgt_c == owner_q);
    for (int i = 0; i < NCH; i++) begin
      if (owner_q == CH_W'(i)) owner_oh_c[i] = 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (fwd_c && owner_oh_c[i]) begin
        wen_c   = ch_wen[i];
        ren_c   = ch_ren[i];
        waddr_c = ch_wen[i] ? ch_waddr[i*AW +: AW] : '0;
        wdata_c = ch_wen[i] ? ch_wdata[i*DW +: DW] : '0;
        raddr_c = ch_ren[i] ? ch_raddr[i*AW +: AW] : '0;
      end
    end
  end

  assign viol_c = (ch_wen | ch_ren) & ~(fwd_c ? owner_oh_c : '0);

  always_comb begin
    viol_lo_c = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (viol_c[i]) viol_lo_c = CH_W'(i);
    end
  end

  always_comb begin
    rvalid_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (tail_valid && (tail_id == CH_W'(i))) rvalid_c[i] = 1'b1;
    end
  end

  // Hand-over FSM: the latest target is sampled at switch time.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    case (state_q)
      S_OWN: begin
        if (tgt_c != owner_q) begin
          state_d = S_DRAIN;
          busy_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (pipe_empty_c) begin
          state_d = S_OWN;
          owner_d = tgt_c;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_OWN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OWN;
      owner_q <= NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_wen   <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
      bram_ren   <= 1'b0;
      bram_raddr <= '0;
      ch_rvalid  <= '0;
      err        <= 1'b0;
      err_ch     <= '0;
    end else begin
      bram_wen   <= wen_c;
      bram_waddr <= waddr_c;
      bram_wdata <= wdata_c;
      bram_ren   <= ren_c;
      bram_raddr <= raddr_c;
      ch_rvalid  <= rvalid_c;
      // A fresh violation beats a simultaneous clear.
      if (|viol_c) begin
        err <= 1'b1;
        if (!err || err_clr) err_ch <= viol_lo_c;
      end else if (err_clr) begin
        err    <= 1'b0;
        err_ch <= '0;
      end
    end
  end

  bram_rd_tag_pipe #(
    .RLAT (RLAT),
    .CH_W (CH_W)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ren_c),
    .push_id    (owner_q),
    .tail_valid (tail_valid),
    .tail_id    (tail_id),
    .empty_c    (pipe_empty_c)
  );

  assign ch_rdata = bram_rdata;
  assign owner    = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: two instances (RLAT=1 and RLAT=3) share
// stimulus; read returns are checked against a scoreboard queue per instance.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
  import kyber_ctrl_pkg::*;

  localparam int unsigned NCH = 4, CH_W = 3, ST_W = 4, AW = 8, DW = 128;
  localparam logic [(2**ST_W)*CH_W-1:0] MAP = build_owner_map();

  typedef struct packed {
    logic [NCH-1:0] oh;
    logic [DW-1:0]  data;
  } ret_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [ST_W-1:0]   cstate;
  logic [NCH-1:0]    ch_wen, ch_ren;
  logic [NCH*AW-1:0] ch_waddr, ch_raddr;
  logic [NCH*DW-1:0] ch_wdata;
  logic              err_clr;

  logic [DW-1:0]   a_rdata, a_wdata, a_brdata, b_rdata, b_wdata, b_brdata;
  logic [NCH-1:0]  a_rvalid, b_rvalid;
  logic            a_wen, a_ren, a_busy, a_err, b_wen, b_ren, b_busy, b_err;
  logic [AW-1:0]   a_waddr, a_raddr, b_waddr, b_raddr;
  logic [CH_W-1:0] a_owner, a_err_ch, b_owner, b_err_ch;

  int   errors = 0;
  int   checks = 0;
  ret_t qa[$];
  ret_t qb[$];

  always #5 clk = ~clk;

  bram_port_arbiter #(.RLAT(1), .OWNER_MAP(MAP)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cstate(cstate),
    .ch_wen(ch_wen), .ch_waddr(ch_waddr), .ch_wdata(ch_wdata),
    .ch_ren(ch_ren), .ch_raddr(ch_raddr),
    .ch_rdata(a_rdata), .ch_rvalid(a_rvalid),
    .bram_wen(a_wen), .bram_waddr(a_waddr), .bram_wdata(a_wdata),
    .bram_ren(a_ren), .bram_raddr(a_raddr), .bram_rdata(a_brdata),
    .owner(a_owner), .busy(a_busy), .err(a_err), .err_ch(a_err_ch), .err_clr(err_clr)
  );

  bram_port_arbiter #(.RLAT(3), .OWNER_MAP(MAP)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cstate(cstate),
    .ch_wen(ch_wen), .ch_waddr(ch_waddr), .ch_wdata(ch_wdata),
    .ch_ren(ch_ren), .ch_raddr(ch_raddr),
    .ch_rdata(b_rdata), .ch_rvalid(b_rvalid),
    .bram_wen(b_wen), .bram_waddr(b_waddr), .bram_wdata(b_wdata),
    .bram_ren(b_ren), .bram_raddr(b_raddr), .bram_rdata(b_brdata),
    .owner(b_owner), .busy(b_busy), .err(b_err), .err_ch(b_err_ch), .err_clr(err_clr)
  );

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {8{a, 8'hC3}};
  endfunction

  // Read-first BRAM models; unwritten words hold init_word(addr).
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  bit   [255:0]  wr_a, wr_b;
  logic [DW-1:0] pa0;
  logic [DW-1:0] pb0, pb1, pb2;

  always @(posedge clk) begin
    pa0 <= a_ren ? (wr_a[a_raddr] ? mem_a[a_raddr] : init_word(a_raddr)) : '0;
    if (a_wen) begin
      mem_a[a_waddr] <= a_wdata;
      wr_a[a_waddr]  <= 1'b1;
    end
  end

  always @(posedge clk) begin
    pb0 <= b_ren ? (wr_b[b_raddr] ? mem_b[b_raddr] : init_word(b_raddr)) : '0;
    pb1 <= pb0;
    pb2 <= pb1;
    if (b_wen) begin
      mem_b[b_waddr] <= b_wdata;
      wr_b[b_waddr]  <= 1'b1;
    end
  end

  assign a_brdata = pa0;
  assign b_brdata = pb2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge, score any read return.
  task automatic step();
    ret_t e;
    @(posedge clk);
    #1;
    if (a_rvalid !== '0) begin
      if (qa.size() == 0) chk("ret_a_unexpected", 128'(a_rvalid), 128'(0));
      else begin
        e = qa.pop_front();
        chk("ret_a_id", 128'(a_rvalid), 128'(e.oh));
        chk("ret_a_data", a_rdata, e.data);
      end
    end
    if (b_rvalid !== '0) begin
      if (qb.size() == 0) chk("ret_b_unexpected", 128'(b_rvalid), 128'(0));
      else begin
        e = qb.pop_front();
        chk("ret_b_id", 128'(b_rvalid), 128'(e.oh));
        chk("ret_b_data", b_rdata, e.data);
      end
    end
  endtask

  task automatic expect_read(input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ret_t e;
    ch_ren[ch]            = 1'b1;
    ch_raddr[ch*AW +: AW] = addr;
    e.oh   = NCH'(1) << ch;
    e.data = data;
    qa.push_back(e);
    qb.push_back(e);
  endtask

  task automatic clear_req();
    ch_wen   = '0;
    ch_ren   = '0;
    ch_waddr = '0;
    ch_raddr = '0;
    ch_wdata = '0;
    err_clr  = 1'b0;
  endtask

  task automatic wait_owner(input logic [CH_W-1:0] o);
    for (int i = 0; i < 20; i++) begin
      if (a_owner == o && b_owner == o) break;
      step();
    end
    chk("owner_a", 128'(a_owner), 128'(o));
    chk("owner_b", 128'(b_owner), 128'(o));
  endtask

  initial begin
    rst_n  = 1'b0;
    cstate = ST_IDLE;
    clear_req();
    step();
    step();
    chk("rst_owner_a", 128'(a_owner), 128'(NCH));
    chk("rst_owner_b", 128'(b_owner), 128'(NCH));
    chk("rst_busy", 128'(a_busy), 128'(0));
    chk("rst_err", 128'(a_err), 128'(0));
    chk("rst_err_ch", 128'(a_err_ch), 128'(0));
    chk("rst_wen", 128'(b_wen), 128'(0));
    chk("rst_ren", 128'(b_ren), 128'(0));
    chk("rst_rvalid", 128'(b_rvalid), 128'(0));
    rst_n = 1'b1;
    step();
    chk("idle_owner", 128'(b_owner), 128'(NCH));

    // PAcc read of word 3
    cstate = ST_PACC;
    step();
    chk("pacc_busy", 128'(b_busy), 128'(1));
    step();
    chk("pacc_owner_a", 128'(a_owner), 128'(CH_PACC));
    chk("pacc_owner_b", 128'(b_owner), 128'(CH_PACC));
    chk("pacc_busy_clr", 128'(b_busy), 128'(0));
    expect_read(1, 8'd3, init_word(8'd3));
    step();
    clear_req();
    chk("rd3_ren_a", 128'(a_ren), 128'(1));
    chk("rd3_raddr_a", 128'(a_raddr), 128'(3));
    chk("rd3_ren_b", 128'(b_ren), 128'(1));
    step();
    chk("rd3_rvalid_a", 128'(a_rvalid), 128'(4'b0010));
    chk("rd3_rdata_a", a_rdata, init_word(8'd3));
    chk("rd3_rvalid_b_early", 128'(b_rvalid), 128'(0));
    repeat (3) step();

    // Hash write, then same-address write+read
    cstate = ST_HASH;
    step();
    step();
    chk("hash_owner", 128'(b_owner), 128'(CH_ATG));
    ch_wen[0]         = 1'b1;
    ch_waddr[0 +: AW] = 8'h12;
    ch_wdata[0 +: DW] = {16{8'hA5}};
    step();
    clear_req();
    chk("wr_wen_a", 128'(a_wen), 128'(1));
    chk("wr_waddr_a", 128'(a_waddr), 128'(8'h12));
    chk("wr_wdata_a", a_wdata, {16{8'hA5}});
    chk("wr_wen_b", 128'(b_wen), 128'(1));
    chk("wr_err", 128'(a_err), 128'(0));
    ch_wen[0]         = 1'b1;
    ch_waddr[0 +: AW] = 8'h20;
    ch_wdata[0 +: DW] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    expect_read(0, 8'h20, init_word(8'h20));
    step();
    clear_req();
    chk("coll_wen", 128'(a_wen), 128'(1));
    chk("coll_ren", 128'(a_ren), 128'(1));
    chk("coll_raddr", 128'(b_raddr), 128'(8'h20));
    step();
    chk("idle_waddr", 128'(a_waddr), 128'(0));
    chk("idle_wdata", a_wdata, 128'(0));

    // PAcc reads in flight while cstate moves to INTT
    cstate = ST_PACC;
    wait_owner(CH_PACC);
    expect_read(1, 8'd5, init_word(8'd5));
    step();
    chk("drn_ren_c1", 128'(b_ren), 128'(1));
    chk("drn_raddr_c1", 128'(b_raddr), 128'(5));
    expect_read(1, 8'd6, init_word(8'd6));
    step();
    clear_req();
    cstate = ST_INTT;
    chk("drn_raddr_c2", 128'(b_raddr), 128'(6));
    step();
    chk("drn_busy_c3", 128'(b_busy), 128'(1));
    chk("drn_ren_c3", 128'(b_ren), 128'(0));
    step();
    chk("drn_busy_c4", 128'(b_busy), 128'(1));
    chk("drn_rvalid_c4", 128'(b_rvalid), 128'(4'b0010));
    chk("drn_rdata_c4", b_rdata, init_word(8'd5));
    step();
    chk("drn_busy_c5", 128'(b_busy), 128'(1));
    chk("drn_rvalid_c5", 128'(b_rvalid), 128'(4'b0010));
    chk("drn_wen_c5", 128'(b_wen), 128'(0));
    step();
    chk("drn_owner_c6", 128'(b_owner), 128'(CH_INTT));
    chk("drn_busy_c6", 128'(b_busy), 128'(0));
    chk("drn_owner_a", 128'(a_owner), 128'(CH_INTT));

    // Non-owner writes under INTT
    ch_wen = 4'b1001;
    step();
    clear_req();
    chk("nown_wen_a", 128'(a_wen), 128'(0));
    chk("nown_wen_b", 128'(b_wen), 128'(0));
    chk("nown_err", 128'(a_err), 128'(1));
    chk("nown_err_ch", 128'(a_err_ch), 128'(0));
    ch_wen = 4'b1000;
    step();
    clear_req();
    chk("sticky_err_ch", 128'(b_err_ch), 128'(0));
    chk("sticky_err", 128'(b_err), 128'(1));
    err_clr = 1'b1;
    step();
    clear_req();
    chk("clr_err", 128'(a_err), 128'(0));
    ch_ren = 4'b1000;
    step();
    clear_req();
    chk("viol3_err_ch", 128'(a_err_ch), 128'(3));
    chk("viol3_ren", 128'(a_ren), 128'(0));
    err_clr   = 1'b1;
    ch_wen[1] = 1'b1;
    step();
    clear_req();
    chk("clr_vs_viol_err", 128'(a_err), 128'(1));
    chk("clr_vs_viol_ch", 128'(a_err_ch), 128'(1));
    err_clr = 1'b1;
    step();
    clear_req();
    chk("clr_err2", 128'(b_err), 128'(0));

    // Add: no owner at all
    cstate = ST_ADD;
    step();
    step();
    chk("add_owner", 128'(a_owner), 128'(NCH));
    ch_wen = 4'b1111;
    ch_ren = 4'b1111;
    step();
    clear_req();
    chk("add_wen", 128'(a_wen), 128'(0));
    chk("add_ren", 128'(b_ren), 128'(0));
    chk("add_err", 128'(a_err), 128'(1));
    chk("add_err_ch", 128'(a_err_ch), 128'(0));
    err_clr = 1'b1;
    step();
    clear_req();

    // Reset with reads in flight
    cstate = ST_PACC;
    wait_owner(CH_PACC);
    expect_read(1, 8'd7, init_word(8'd7));
    step();
    expect_read(1, 8'd8, init_word(8'd8));
    step();
    clear_req();
    rst_n = 1'b0;
    #1;
    chk("mrst_ren_b", 128'(b_ren), 128'(0));
    chk("mrst_raddr_b", 128'(b_raddr), 128'(0));
    chk("mrst_rvalid_a", 128'(a_rvalid), 128'(0));
    chk("mrst_owner_b", 128'(b_owner), 128'(NCH));
    qa.delete();
    qb.delete();
    cstate = ST_IDLE;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_rvalid_a", 128'(a_rvalid), 128'(0));
      chk("post_rst_rvalid_b", 128'(b_rvalid), 128'(0));
    end
    chk("post_rst_owner", 128'(b_owner), 128'(NCH));
    chk("qa_empty", 128'(qa.size()), 128'(0));
    chk("qb_empty", 128'(qb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
